mdu_issue_ctrl: RTL and testbench

- Pipeline-side initiator for the multi-cycle multiply/divide execute unit (start/valid protocol, result held until the next start).
- Accepts one mul/div request from the EX stage and registers its operands.
- Pulses start to the unit, waits for valid, captures the result and presents a one-cycle writeback.
- Stalls the front of the pipeline while busy. Handles flush, unit timeout and a destination-register busy tag.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_timeout_cnt.sv | 28 ++
 rtl/mdu_issue_ctrl.sv | 135 +++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared state encoding, opcode values and default widths for the MDU issue controller.
package mdu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB,
        DRAIN
    } mdu_state_t;

    localparam int OP_MUL      = 0;
    localparam int OP_DIV      = 1;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_OP_W    = 3;
    localparam int DEF_RD_W    = 5;
    localparam int DEF_TIMEOUT = 63;

    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mdu_timeout_cnt.sv
// mdu_timeout_cnt: saturating cycle counter with synchronous clear, enable and an at-limit flag.
module mdu_timeout_cnt import mdu_pkg::*; #(
    parameter int LIMIT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_limit
);

    localparam int CW = cnt_width(LIMIT);

    logic [CW-1:0] cnt;

    assign at_limit = (cnt == CW'(LIMIT));

    // Holding at LIMIT keeps at_limit asserted until the next clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !at_limit)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issues one mul/div op to the multi-cycle MDU and presents a one-cycle writeback.
// Optional MDU_DIV0_BYPASS_EN: divide-by-zero completes locally with an all-ones result.
module mdu_issue_ctrl import mdu_pkg::*; #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OP_W    = DEF_OP_W,
    parameter int RD_W    = DEF_RD_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [RD_W-1:0]   req_rd,
    input  logic              flush,
    output logic              mdu_start,
    output logic [OP_W-1:0]   mdu_op,
    output logic [DATA_W-1:0] mdu_a,
    output logic [DATA_W-1:0] mdu_b,
    input  logic              mdu_valid,
    input  logic [DATA_W-1:0] mdu_result,
    output logic              stall,
    output logic [RD_W-1:0]   busy_rd,
    output logic              busy_rd_vld,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_err
);

    mdu_state_t      state, state_nx;
    logic [RD_W-1:0] rd_q;
    logic            err_q;
    logic            accept, bypass, to_hit, done, capture, abort;

    assign accept = (state == IDLE) && req_valid && !flush;

`ifdef MDU_DIV0_BYPASS_EN
    assign bypass = accept && (req_op != OP_W'(OP_MUL)) && (req_b == '0);
`else
    assign bypass = 1'b0;
`endif

    assign done    = mdu_valid || to_hit;
    assign capture = (state == WAIT) && !flush && mdu_valid;
    assign abort   = (state == WAIT) && !flush && !mdu_valid && to_hit;

    mdu_timeout_cnt #(.LIMIT(TIMEOUT)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == ISSUE),
        .en       ((state == WAIT) || (state == DRAIN)),
        .at_limit (to_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // A flush in WAIT beats a same-cycle valid; DRAIN then waits out the unit.
    always_comb begin
        state_nx    = state;
        req_ready   = 1'b0;
        mdu_start   = 1'b0;
        stall       = 1'b1;
        busy_rd_vld = 1'b0;
        wb_valid    = 1'b0;
        wb_err      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                stall     = 1'b0;
                state_nx  = accept ? (bypass ? WB : ISSUE) : IDLE;
            end
            ISSUE: begin
                mdu_start   = 1'b1;
                busy_rd_vld = 1'b1;
                state_nx    = flush ? DRAIN : WAIT;
            end
            WAIT: begin
                busy_rd_vld = 1'b1;
                state_nx    = flush ? DRAIN : (done ? WB : WAIT);
            end
            WB: begin
                busy_rd_vld = 1'b1;
                wb_valid    = 1'b1;
                wb_err      = err_q;
                state_nx    = IDLE;
            end
            DRAIN: begin
                state_nx = done ? IDLE : DRAIN;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdu_op  <= '0;
            mdu_a   <= '0;
            mdu_b   <= '0;
            rd_q    <= '0;
            wb_data <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                mdu_op <= req_op;
                mdu_a  <= req_a;
                mdu_b  <= req_b;
                rd_q   <= req_rd;
            end
            if (bypass) begin
                wb_data <= '1;
                err_q   <= 1'b0;
            end else if (capture) begin
                wb_data <= mdu_result;
                err_q   <= 1'b0;
            end else if (abort) begin
                wb_data <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign busy_rd = rd_q;
    assign wb_rd   = rd_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl: randomized self-checking bench with a cycle-level outcome model and a responder MDU.
module tb_mdu_issue_ctrl;

    localparam int TO = 63;

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_rd;
    logic        flush;
    logic        mdu_start;
    logic [2:0]  mdu_op;
    logic [31:0] mdu_a, mdu_b;
    logic        mdu_valid;
    logic [31:0] mdu_result;
    logic        stall;
    logic [4:0]  busy_rd;
    logic        busy_rd_vld;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;

    int vecs = 0;
    int errs = 0;
    int unit_dly = 1;

    mdu_issue_ctrl #(.DATA_W(32), .OP_W(3), .RD_W(5), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
        .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_a(mdu_a), .mdu_b(mdu_b),
        .mdu_valid(mdu_valid), .mdu_result(mdu_result), .stall(stall),
        .busy_rd(busy_rd), .busy_rd_vld(busy_rd_vld), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 3'd0) return a * b;
        return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    endfunction

    // Responder unit: valid rises unit_dly cycles after the start cycle and holds until the next start.
    initial begin
        logic        st, pend;
        logic [2:0]  so;
        logic [31:0] sa, sb, ures;
        int          cnt;
        mdu_valid  = 1'b0;
        mdu_result = '0;
        pend       = 1'b0;
        cnt        = 0;
        ures       = '0;
        forever begin
            @(negedge clk);
            st = mdu_start;
            so = mdu_op;
            sa = mdu_a;
            sb = mdu_b;
            @(posedge clk);
            #1;
            if (st === 1'b1) begin
                ures      = ref_result(so, sa, sb);
                mdu_valid = 1'b0;
                pend      = 1'b0;
                if (unit_dly <= 1) begin
                    mdu_valid  = 1'b1;
                    mdu_result = ures;
                end else begin
                    pend = 1'b1;
                    cnt  = unit_dly - 2;
                end
            end else if (pend) begin
                if (cnt == 0) begin
                    mdu_valid  = 1'b1;
                    mdu_result = ures;
                    pend       = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Cycle 0 is the accept cycle; the model predicts the writeback cycle, the
    // first idle cycle and the last busy-tag cycle from the op timing alone.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int dly, input int f, input bit chain,
                          input string nm);
        bit          byp, exp_e, exp_wbv, exp_bv;
        logic [31:0] res, exp_d;
        logic [4:0]  exp_ctl;
        int          vc, dec, wbc, endc, bend, last;
        byp = 1'b0;
`ifdef MDU_DIV0_BYPASS_EN
        byp = (op != 3'd0) && (b == 32'd0);
`endif
        res = ref_result(op, a, b);
        vc  = 1 + dly;
        dec = (vc <= TO + 2) ? vc : TO + 2;
        if (byp) begin
            wbc = 1; endc = 2; bend = 2; exp_d = 32'hFFFF_FFFF; exp_e = 1'b0;
        end else if (f >= 1 && f <= dec) begin
            wbc = -1; endc = ((f + 1 > dec) ? f + 1 : dec) + 1; bend = f + 1; exp_d = '0; exp_e = 1'b0;
        end else begin
            wbc = dec + 1; endc = wbc + 1; bend = endc;
            exp_d = (vc <= TO + 2) ? res : 32'd0;
            exp_e = (vc > TO + 2);
        end
        last     = chain ? endc - 1 : endc;
        unit_dly = dly;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            req_valid = (c == 0);
            req_op    = (c == 0) ? op : 3'($urandom);
            req_a     = (c == 0) ? a : $urandom;
            req_b     = (c == 0) ? b : $urandom;
            req_rd    = (c == 0) ? rd : 5'($urandom);
            flush     = (f != 0) && (c == f);
            @(negedge clk);
            exp_wbv = (c == wbc);
            exp_bv  = (c >= 1) && (c < bend);
            exp_ctl = {(c == 0) || (c >= endc), (c >= 1) && (c < endc), !byp && (c == 1), exp_wbv, exp_bv};
            vecs++;
            if ({req_ready, stall, mdu_start, wb_valid, busy_rd_vld} !== exp_ctl) begin
                errs++;
                $display("FAIL %s ctl c%0d got rdy/stall/start/wbv/bvld=%b exp %b", nm, c,
                         {req_ready, stall, mdu_start, wb_valid, busy_rd_vld}, exp_ctl);
            end
            if (exp_wbv) begin
                vecs++;
                if ({wb_rd, wb_data, wb_err} !== {rd, exp_d, exp_e}) begin
                    errs++;
                    $display("FAIL %s wb c%0d got rd=%0d data=%h err=%b exp rd=%0d data=%h err=%b",
                             nm, c, wb_rd, wb_data, wb_err, rd, exp_d, exp_e);
                end
            end
            if (!byp && c >= 1) begin
                vecs++;
                if ({mdu_op, mdu_a, mdu_b} !== {op, a, b}) begin
                    errs++;
                    $display("FAIL %s operands c%0d got op=%0d a=%h b=%h exp op=%0d a=%h b=%h",
                             nm, c, mdu_op, mdu_a, mdu_b, op, a, b);
                end
            end
            if (exp_bv) begin
                vecs++;
                if (busy_rd !== rd) begin
                    errs++;
                    $display("FAIL %s busy_rd c%0d got %0d exp %0d", nm, c, busy_rd, rd);
                end
            end
        end
        req_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vecs++;
        if ({req_ready, mdu_start, mdu_op, mdu_a, mdu_b, stall, busy_rd, busy_rd_vld,
             wb_valid, wb_rd, wb_data, wb_err} !== '0) begin
            errs++;
            $display("FAIL reset_outputs got rdy=%b stall=%b wbv=%b a=%h exp all zero",
                     req_ready, stall, wb_valid, mdu_a);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if ({req_ready, stall} !== 2'b10) begin
            errs++;
            $display("FAIL reset_release got rdy/stall=%b exp 10", {req_ready, stall});
        end
    endtask

    task automatic test_mul();
        run_op(3'd0, 32'd7, 32'd6, 5'd3, 10, 0, 1'b0, "mul");
    endtask

    task automatic test_div();
        run_op(3'd1, 32'd100, 32'd7, 5'd9, 40, 0, 1'b0, "div");
    endtask

    task automatic test_timeout();
        run_op(3'd1, 32'd50, 32'd5, 5'd17, 1000, 0, 1'b0, "timeout");
        run_op(3'd0, 32'd11, 32'd13, 5'd18, TO + 1, 0, 1'b0, "valid_at_limit");
        run_op(3'd0, 32'd11, 32'd13, 5'd19, TO + 2, 0, 1'b0, "valid_after_limit");
    endtask

    task automatic test_flush();
        run_op(3'd0, 32'd3, 32'd4, 5'd5, 10, 7, 1'b0, "flush_wait");
        run_op(3'd2, 32'd90, 32'd9, 5'd6, 4, 1, 1'b0, "flush_issue");
        run_op(3'd0, 32'd8, 32'd8, 5'd7, 6, 7, 1'b0, "flush_with_valid");
        run_op(3'd0, 32'd5, 32'd5, 5'd8, 6, 8, 1'b0, "flush_in_wb");
        run_op(3'd1, 32'd9, 32'd3, 5'd10, 1000, 20, 1'b0, "flush_then_timeout");
    endtask

    task automatic test_flush_on_accept();
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        flush     = 1'b1;
        req_op    = 3'd0;
        req_a     = 32'd2;
        req_b     = 32'd2;
        req_rd    = 5'd4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecs++;
            if ({req_ready, stall, mdu_start, wb_valid} !== 4'b1000) begin
                errs++;
                $display("FAIL flush_on_accept c%0d got rdy/stall/start/wbv=%b exp 1000", i,
                         {req_ready, stall, mdu_start, wb_valid});
            end
        end
    endtask

    task automatic test_async_reset();
        unit_dly = 10;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 32'd5;
        req_b     = 32'd9;
        req_rd    = 5'd12;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        vecs++;
        if ({stall, busy_rd_vld} !== 2'b11) begin
            errs++;
            $display("FAIL areset_pre got stall/bvld=%b exp 11", {stall, busy_rd_vld});
        end
        #2;
        rst = 1'b1;
        #1;
        vecs++;
        if ({req_ready, mdu_start, mdu_op, mdu_a, mdu_b, stall, busy_rd, busy_rd_vld,
             wb_valid, wb_rd, wb_data, wb_err} !== '0) begin
            errs++;
            $display("FAIL areset_outputs got rdy=%b stall=%b bvld=%b a=%h exp all zero",
                     req_ready, stall, busy_rd_vld, mdu_a);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vecs++;
            if ({req_ready, stall, wb_valid, busy_rd_vld} !== 4'b1000) begin
                errs++;
                $display("FAIL areset_after c%0d got rdy/stall/wbv/bvld=%b exp 1000", i,
                         {req_ready, stall, wb_valid, busy_rd_vld});
            end
        end
        vecs++;
        if (wb_data !== 32'd0) begin
            errs++;
            $display("FAIL areset_wb_data got %h exp 0", wb_data);
        end
    endtask

    task automatic test_div0();
        run_op(3'd1, 32'd55, 32'd0, 5'd21, 5, 0, 1'b0, "div0");
        run_op(3'd0, 32'd55, 32'd0, 5'd22, 3, 0, 1'b0, "mul_by_zero");
    endtask

    task automatic test_back_to_back();
        run_op(3'd0, 32'd12, 32'd12, 5'd1, 1, 0, 1'b1, "b2b_0");
        run_op(3'd3, 32'd77, 32'd0, 5'd2, 2, 0, 1'b1, "b2b_1");
        run_op(3'd1, 32'd1000, 32'd10, 5'd3, 3, 2, 1'b1, "b2b_2");
        run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 5'd4, 1, 0, 1'b0, "b2b_3");
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        int          dly, f;
        for (int n = 0; n < 40; n++) begin
            op  = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
            dly = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 6) : $urandom_range(1, 40);
            f   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, dly + 3) : 0;
            run_op(op, a, b, 5'($urandom), dly, f, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_rd    = '0;
        flush     = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_timeout();
        test_flush();
        test_flush_on_accept();
        test_async_reset();
        test_div0();
        test_back_to_back();
        test_random();
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
